// File: rtl/rand_delay_pkg.sv
// Shared types and defaults for the random-delay timer: FSM state encoding
// and the LFSR-value-to-delay mapping.
package rand_delay_pkg;

  localparam int DEF_DELAY_W    = 7;
  localparam int DEF_MIN_DELAY  = 4;
  localparam int DEF_PRESCALE   = 1000;
  localparam int DEF_PRESCALE_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COUNT   = 2'd2,
    FIRE    = 2'd3
  } rd_state_t;

  // Zero is the LFSR lock-up value; treat it as 1 so every run has a real delay.
  // Callers truncate the 16-bit result to DELAY_W+1 bits (DELAY_W <= 15).
  function automatic logic [15:0] lfsr_to_delay(input logic [15:0] value,
                                                input logic [15:0] min_delay);
    return ((value == 16'd0) ? 16'd1 : value) + min_delay;
  endfunction

endpackage

// File: rtl/rand_delay_timer_tick_gen.sv
// Prescaler: modulo-PRESCALE counter that pulses tick on its terminal count
// while enabled.
module tick_gen #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 10
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/rand_delay_timer.sv
// Random-wait stage: captures an LFSR value on start, counts it out in
// prescaled units, then pulses fire. All outputs decode from registers.
module rand_delay_timer
  import rand_delay_pkg::*;
#(
  parameter int DELAY_W    = DEF_DELAY_W,
  parameter int MIN_DELAY  = DEF_MIN_DELAY,
  parameter int PRESCALE   = DEF_PRESCALE,
  parameter int PRESCALE_W = DEF_PRESCALE_W
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] lfsr_value,
  output logic               lfsr_advance,
  output logic               busy,
  output logic               fire,
  output logic [DELAY_W:0]   delay_q
);

  localparam int DW = DELAY_W + 1;

  rd_state_t     state, state_nxt;
  logic [DW-1:0] delay_nxt;
  logic [DW-1:0] delay_load;
  logic          tick, tick_clear, tick_en;

  assign delay_load = DW'(lfsr_to_delay(16'(lfsr_value), 16'(MIN_DELAY)));

  assign tick_en    = (state == COUNT);
  assign tick_clear = (state == CAPTURE) || abort;

  tick_gen #(
    .PRESCALE  (PRESCALE),
    .PRESCALE_W(PRESCALE_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    delay_nxt = delay_q;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = IDLE;
          delay_nxt = '0;
        end else begin
          state_nxt = COUNT;
          delay_nxt = delay_load;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt = IDLE;
          delay_nxt = '0;
        end else if (tick) begin
          delay_nxt = delay_q - DW'(1);
          if (delay_q == DW'(1)) state_nxt = FIRE;
        end
      end
      FIRE: begin
        // start is deliberately not looked at here: requests while busy are dropped
        state_nxt = IDLE;
        delay_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        delay_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      delay_q <= '0;
    end else begin
      state   <= state_nxt;
      delay_q <= delay_nxt;
    end
  end

  assign busy         = (state != IDLE);
  assign lfsr_advance = (state == CAPTURE);
  assign fire         = (state == FIRE);

endmodule

// File: tb/tb_rand_delay_timer.sv
// Bench for rand_delay_timer: timing-formula model checked every cycle on two
// instances (PRESCALE=4 and PRESCALE=1), plus hand-computed literal checks.
module tb_rand_delay_timer;

  localparam int MIN = 4;

  logic       clk = 0;
  logic       rst;
  logic       start_i [2];
  logic       abort_i [2];
  logic [6:0] lfsr_i  [2];
  logic       adv_o   [2];
  logic       busy_o  [2];
  logic       fire_o  [2];
  logic [7:0] dq_o    [2];

  int checks = 0, failures = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit act [2];
  int t0 [2];
  int dm [2];
  int fire_cnt [2];
  int adv_cnt  [2];

  always #5 clk = ~clk;

  rand_delay_timer #(.DELAY_W(7), .MIN_DELAY(MIN), .PRESCALE(4), .PRESCALE_W(2)) dut (
    .clk(clk), .rst(rst), .start(start_i[0]), .abort(abort_i[0]), .lfsr_value(lfsr_i[0]),
    .lfsr_advance(adv_o[0]), .busy(busy_o[0]), .fire(fire_o[0]), .delay_q(dq_o[0]));

  rand_delay_timer #(.DELAY_W(7), .MIN_DELAY(MIN), .PRESCALE(1), .PRESCALE_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .abort(abort_i[1]), .lfsr_value(lfsr_i[1]),
    .lfsr_advance(adv_o[1]), .busy(busy_o[1]), .fire(fire_o[1]), .delay_q(dq_o[1]));

  function automatic int pre(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // 0 idle, 1 capture, 2 count, 3 fire -- from the run's start cycle and D alone
  function automatic int phase(int i, int c);
    if (!act[i] || c <= t0[i]) return 0;
    if (c == t0[i] + 1) return 1;
    if (c <= t0[i] + 1 + dm[i] * pre(i)) return 2;
    if (c == t0[i] + 2 + dm[i] * pre(i)) return 3;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act_v, exp_v);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ph;
      ph = phase(i, cyc);
      if (rst) act[i] = 0;
      else if (ph != 0 && abort_i[i]) act[i] = 0;
      else if (ph == 0 && start_i[i] && !abort_i[i]) begin
        act[i] = 1;
        t0[i]  = cyc;
        dm[i]  = ((lfsr_i[i] == 0) ? 1 : int'(lfsr_i[i])) + MIN;
      end
    end
    if (rst) chk_en = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ph, edq;
        ph  = phase(i, cyc);
        edq = (ph == 2) ? dm[i] - (cyc - (t0[i] + 2)) / pre(i) : 0;
        chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(ph != 0));
        chk($sformatf("adv%0d", i),  int'(adv_o[i]),  int'(ph == 1));
        chk($sformatf("fire%0d", i), int'(fire_o[i]), int'(ph == 3));
        chk($sformatf("dq%0d", i),   int'(dq_o[i]),   edq);
        if (fire_o[i] === 1'b1) fire_cnt[i]++;
        if (adv_o[i] === 1'b1)  adv_cnt[i]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic go(input int i, input logic [6:0] v, output int t);
    lfsr_i[i]  = v;
    start_i[i] = 1;
    t = cyc;
    step(1);
    start_i[i] = 0;
  endtask

  task automatic wait_fire(input int i, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      step(1);
      if (fire_o[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t, at, f, a;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 0; abort_i[i] = 0; lfsr_i[i] = '0;
      act[i] = 0; t0[i] = 0; dm[i] = 0; fire_cnt[i] = 0; adv_cnt[i] = 0;
    end
    step(2);
    start_i[0] = 1;
    step(1);
    start_i[0] = 0;
    chk("rst_busy", int'(busy_o[0]), 0);
    rst = 0;
    step(2);
    chk("post_rst_busy", int'(busy_o[0]), 0);

    // normal run, D=9
    go(0, 7'h05, t);
    chk("cap_adv", int'(adv_o[0]), 1);
    tick_to(t + 2);
    chk("load_dq", int'(dq_o[0]), 9);
    lfsr_i[0] = 7'h33;
    wait_fire(0, 100, at);
    chk("normal_fire_t", at - t, 38);
    tick_to(t + 39);
    chk("normal_busy_end", int'(busy_o[0]), 0);

    // lock-up value, D=5
    step(2);
    go(0, 7'h00, t);
    wait_fire(0, 100, at);
    chk("zero_fire_t", at - t, 22);

    // maximum value, D=131
    step(1);
    go(0, 7'h7F, t);
    tick_to(t + 2);
    chk("max_dq", int'(dq_o[0]), 131);
    wait_fire(0, 600, at);
    chk("max_fire_t", at - t, 526);

    // abort mid-count
    step(1);
    go(0, 7'h05, t);
    tick_to(t + 10);
    abort_i[0] = 1;
    step(1);
    abort_i[0] = 0;
    chk("abort_busy", int'(busy_o[0]), 0);
    chk("abort_dq", int'(dq_o[0]), 0);
    f = fire_cnt[0];
    step(50);
    chk("abort_nofire", fire_cnt[0] - f, 0);

    // start with abort in idle
    start_i[0] = 1; abort_i[0] = 1;
    step(1);
    start_i[0] = 0; abort_i[0] = 0;
    chk("sa_idle_busy", int'(busy_o[0]), 0);

    // abort during FIRE still shows fire
    step(1);
    go(0, 7'h00, t);
    tick_to(t + 22);
    chk("fire_abort_fire", int'(fire_o[0]), 1);
    abort_i[0] = 1;
    step(1);
    abort_i[0] = 0;
    chk("fire_abort_busy", int'(busy_o[0]), 0);

    // starts while busy are dropped; start right after FIRE is taken
    step(2);
    a = adv_cnt[0];
    f = fire_cnt[0];
    go(0, 7'h01, t);
    tick_to(t + 10);
    start_i[0] = 1;
    step(1);
    start_i[0] = 0;
    tick_to(t + 22);
    chk("busy_fire_lit", int'(fire_o[0]), 1);
    start_i[0] = 1;
    step(1);
    step(1);
    start_i[0] = 0;
    chk("after_fire_busy", int'(busy_o[0]), 1);
    chk("after_fire_adv", int'(adv_o[0]), 1);
    wait_fire(0, 100, at);
    chk("second_fire_t", at - t, 45);
    step(2);
    chk("adv_per_run", adv_cnt[0] - a, 2);
    chk("fire_per_run", fire_cnt[0] - f, 2);

    // reset mid-count
    go(0, 7'h05, t);
    tick_to(t + 8);
    rst = 1;
    step(1);
    rst = 0;
    chk("midrst_busy", int'(busy_o[0]), 0);
    chk("midrst_dq", int'(dq_o[0]), 0);
    f = fire_cnt[0];
    step(50);
    chk("midrst_nofire", fire_cnt[0] - f, 0);

    // PRESCALE=1 instance
    go(1, 7'h01, t);
    wait_fire(1, 30, at);
    chk("p1_fire_t", at - t, 7);

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_delay_timer.md
# rand_delay_timer

Downstream consumer of the 7-bit LFSR. On a start request it captures the current pseudo-random LFSR value, converts it to a bounded delay, counts that delay out in prescaled time units, then emits a one-cycle `fire` pulse. It also advances the LFSR once per captured value, so consecutive runs see fresh values. It is the random-wait stage of the reaction/pattern logic that sits behind the LFSR in the Tiny Tapeout design.

## Interface
Parameters:
- `DELAY_W`, default 7: LFSR value width; the internal delay counter is `DELAY_W+1` bits.
- `MIN_DELAY`, default 4: offset added to every captured value; must be ≤ 128.
- `PRESCALE`, default 1000: clocks per delay unit; must be ≥ 1.
- `PRESCALE_W`, default 10: prescaler counter width, with `2**PRESCALE_W ≥ PRESCALE`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new timed run; honoured only in IDLE.
- `abort` in 1: cancel the run in progress; no `fire` is produced.
- `lfsr_value` in `DELAY_W`: the LFSR's current output.
- `lfsr_advance` out 1: one-cycle pulse; drives the LFSR's `enable`.
- `busy` out 1: high in every non-IDLE state.
- `fire` out 1: one-cycle pulse when the delay expires.
- `delay_q` out `DELAY_W+1`: the remaining delay units, for debug.

## Operation
The block is a four-state FSM: IDLE, CAPTURE, COUNT, FIRE.

- **IDLE**
  - If `start=1` and `abort=0`, go to CAPTURE.
  - Otherwise stay in IDLE.
- **CAPTURE** (exactly 1 cycle)
  - Load `delay_q ← (lfsr_value==0 ? 1 : lfsr_value) + MIN_DELAY`, using `DELAY_W+1`-bit arithmetic with no overflow possible.
  - A zero value is the LFSR lock-up state; it is mapped to 1.
  - Assert `lfsr_advance`.
  - Clear the prescaler, then go to COUNT.
- **COUNT**
  - The prescaler counts 0…PRESCALE−1 and wraps to 0.
  - On the terminal count, decrement `delay_q`.
  - If the terminal count occurs while `delay_q==1`, `delay_q` becomes 0 and the next state is FIRE.
- **FIRE** (exactly 1 cycle)
  - Assert `fire`, then go to IDLE.
  - `delay_q` holds 0.
- **abort**
  - `abort=1` in CAPTURE, COUNT or FIRE moves the FSM to IDLE on the next edge.
  - The abort cycle's own outputs are unaffected: a FIRE-state cycle still shows `fire=1`, and a CAPTURE-state cycle still shows `lfsr_advance=1`.
  - After an abort, `delay_q` is cleared to 0.
- **Simultaneous events**
  - `start` together with `abort` in IDLE: abort wins, and the FSM stays in IDLE.
  - `start` while busy, including in FIRE, is ignored and not queued.
- **Reset**
  - `rst=1` at any point, including mid-count, forces IDLE and clears the prescaler.
  - Reset values: `delay_q=0`, `busy=0`, `fire=0`, `lfsr_advance=0`.
  - Reset takes priority over `start` and `abort`.
- **Output timing:** all outputs are registered or decoded purely from state; there is no combinational path from an input to any output.

## Timing
- Let T0 be the cycle in which `start` is sampled high in IDLE, and D the value loaded into `delay_q`.
- CAPTURE occurs in cycle T0+1; `lfsr_advance=1` in T0+1 only.
- COUNT spans cycles T0+2 … T0+1+D·PRESCALE.
- `fire=1` in cycle T0+2+D·PRESCALE only.
- `busy=1` from T0+1 through the FIRE cycle inclusive.
- The earliest next accepted `start` is the cycle after FIRE.
- D ranges from 1+MIN_DELAY to 2^DELAY_W−1+MIN_DELAY, i.e. 5…131 with the defaults.
- Throughput: at most one `lfsr_advance` per run.

## Structure
- Shared package `rand_delay_pkg`:
  - state enum `rd_state_t` {IDLE, CAPTURE, COUNT, FIRE};
  - default parameter constants;
  - function `lfsr_to_delay(value)` implementing the zero-mapping and the offset.
- Sub-module `tick_gen`:
  - a PRESCALE-modulo counter with synchronous `clear` and an `en` input;
  - produces a one-cycle `tick` output on the terminal count;
  - `en` is high only in COUNT, and `clear` is driven in CAPTURE and on reset/abort.
- The top level holds the FSM and the delay counter.

## Test plan
Directed scenarios use PRESCALE=4 and MIN_DELAY=4 unless stated otherwise.
- **Reset:** hold `rst` for 3 cycles → all outputs are 0 and the state is IDLE. Pulse `start` during `rst` → no `busy`.
- **Normal run:** `lfsr_value=7'h05`, pulse `start` at T0 → `lfsr_advance` at T0+1, `delay_q=9` at T0+2, `fire` only at T0+38, `busy` low at T0+39.
- **Lock-up and maximum boundaries:**
  - `lfsr_value=0` → D=5 and `fire` at T0+22.
  - `lfsr_value=7'h7F` → D=131 and `fire` at T0+526, with no wrap of `delay_q`.
- **Abort:** `abort` at T0+10 → IDLE at T0+11, `delay_q=0`, no `fire` ever.
  - `start`+`abort` together in IDLE → stays in IDLE.
- **Start while busy:** extra `start` pulses during COUNT and during the FIRE cycle → ignored, with exactly one `fire` and one `lfsr_advance` per accepted run.
  - A `start` the cycle after FIRE is accepted.
- **Mid-run reset and PRESCALE=1:**
  - `rst` asserted mid-COUNT → IDLE on the next edge with no `fire`.
  - With PRESCALE=1, `lfsr_value=1` → D=5 and `fire` at T0+7.
